// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver.
// Glyphs are active-low, bit 6 = g ... bit 0 = a.
package seg7_pkg;

  localparam int unsigned SEG_DIGITS = 4;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment glyph; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_DASH;
    case (bcd_i)
      4'd0:    seg_o = GLYPH_0;
      4'd1:    seg_o = GLYPH_1;
      4'd2:    seg_o = GLYPH_2;
      4'd3:    seg_o = GLYPH_3;
      4'd4:    seg_o = GLYPH_4;
      4'd5:    seg_o = GLYPH_5;
      4'd6:    seg_o = GLYPH_6;
      4'd7:    seg_o = GLYPH_7;
      4'd8:    seg_o = GLYPH_8;
      4'd9:    seg_o = GLYPH_9;
      default: seg_o = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed MM:SS display driver: per-frame snapshot of the BCD count,
// leading-zero blanking, colon on minutes-units and whole-display blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic [16:1] Q,
  input  logic        LZB,
  input  logic        BLINK_EN,
  output logic [7:1]  SEG,
  output logic        DP,
  output logic [4:1]  AN
);

  localparam int unsigned PCNT_W = $clog2(SCAN_DIV);
  localparam int unsigned FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(SEG_DIGITS);

  localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(SCAN_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEG_DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_COLON = IDX_W'(2);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [16:1]       snap_q, snap_d;
  logic              primed_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic              blink_en_q;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;

  logic       tick, wrap, blank;
  logic [3:0] digit;
  logic [6:0] glyph;

  // Scan timing is frozen until the first snapshot is taken.
  assign tick = primed_q && (pcnt_q == PCNT_MAX);
  assign wrap = tick && (idx_q == IDX_LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (primed_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (!primed_q || wrap) begin
      snap_d = Q;
    end
  end

  // A wrap landing in the same cycle BLINK_EN rises is not counted.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!BLINK_EN) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (wrap && blink_en_q) begin
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_comb begin
    digit = 4'd0;
    unique case (idx_q)
      IDX_W'(0): digit = snap_q[4:1];
      IDX_W'(1): digit = snap_q[8:5];
      IDX_W'(2): digit = snap_q[12:9];
      IDX_W'(3): digit = snap_q[16:13];
      default:   digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (glyph)
  );

  assign blank = LZB && (idx_q == IDX_LAST) && (snap_q[16:13] == 4'd0);

  always_comb begin
    an_d  = 4'b1111;
    seg_d = GLYPH_BLANK;
    dp_d  = 1'b1;
    if (primed_q) begin
      seg_d = blank ? GLYPH_BLANK : glyph;
      if (!phase_q && !blank) begin
        an_d = ~(4'b0001 << idx_q);
      end
      if (!phase_q && (idx_q == IDX_COLON)) begin
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      primed_q   <= 1'b0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      blink_en_q <= 1'b0;
      seg_q      <= GLYPH_BLANK;
      dp_q       <= 1'b1;
      an_q       <= 4'b1111;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      primed_q   <= 1'b1;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      blink_en_q <= BLINK_EN;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign SEG = seg_q;
  assign DP  = dp_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLINK_DIV=2 (16-cycle frames).
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        RESET;
  logic [16:1] Q;
  logic        LZB;
  logic        BLINK_EN;
  logic [7:1]  SEG;
  logic        DP;
  logic [4:1]  AN;

  int n_chk = 0;
  int n_bad = 0;

  seg7_scan_driver #(
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk_in   (clk_in),
    .RESET    (RESET),
    .Q        (Q),
    .LZB      (LZB),
    .BLINK_EN (BLINK_EN),
    .SEG      (SEG),
    .DP       (DP),
    .AN       (AN)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp);
    check({tag, " AN"}, 16'(AN), 16'(e_an));
    check({tag, " SEG"}, 16'(SEG), 16'(e_seg));
    check({tag, " DP"}, 16'(DP), 16'(e_dp));
  endtask

  // One 16-cycle frame; optionally drives Q/BLINK_EN right after slot edge chg_at.
  task automatic run_frame(input string tag, input logic [15:0] val, input logic lzb,
                           input logic dark, input int chg_at, input logic [15:0] chg_q,
                           input logic chg_en);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] nib;
      logic       blank;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      nib   = val[d*4 +: 4];
      blank = lzb && (d == 3) && (nib == 4'd0);
      e_an  = (dark || blank) ? 4'b1111 : ~(4'b0001 << d);
      e_seg = blank ? 7'h7F : glyph(nib);
      e_dp  = !((d == 2) && !dark);
      for (int k = 0; k < 4; k++) begin
        step();
        check_out($sformatf("%s d%0d e%0d", tag, d, k), e_an, e_seg, e_dp);
        if (d * 4 + k == chg_at) begin
          Q        = chg_q;
          BLINK_EN = chg_en;
        end
      end
    end
  endtask

  task automatic frame(input string tag, input logic [15:0] val, input logic lzb,
                       input logic dark);
    run_frame(tag, val, lzb, dark, -1, 16'h0, 1'b0);
  endtask

  initial begin
    RESET    = 1'b1;
    Q        = 16'h1020;
    LZB      = 1'b0;
    BLINK_EN = 1'b0;
    repeat (3) step();
    check_out("in_reset", 4'b1111, 7'h7F, 1'b1);
    RESET = 1'b0;

    // Start sequence: edge 1 dark, digit 0 from edge 2.
    step();
    check_out("start_e1", 4'b1111, 7'h7F, 1'b1);
    frame("start0", 16'h1020, 1'b0, 1'b0);
    frame("start1", 16'h1020, 1'b0, 1'b0);

    // Tear-free: Q changes while digit 1 lit only shows next frame.
    Q = 16'h4930;
    frame("pre_tear", 16'h1020, 1'b0, 1'b0);
    run_frame("tear", 16'h4930, 1'b0, 1'b0, 5, 16'h4929, 1'b0);
    frame("post_tear", 16'h4929, 1'b0, 1'b0);

    // Leading-zero blanking.
    Q   = 16'h0959;
    LZB = 1'b1;
    frame("lz_pre", 16'h4929, 1'b1, 1'b0);
    frame("lz_on", 16'h0959, 1'b1, 1'b0);
    LZB = 1'b0;
    frame("lz_off", 16'h0959, 1'b0, 1'b0);

    // Non-BCD nibbles show a dash.
    Q = 16'h1A2F;
    frame("bad_pre", 16'h0959, 1'b0, 1'b0);
    frame("bad", 16'h1A2F, 1'b0, 1'b0);

    // Blink: two frames lit, then dark; drop BLINK_EN while dark.
    BLINK_EN = 1'b1;
    frame("blink_n0", 16'h1A2F, 1'b0, 1'b0);
    frame("blink_n1", 16'h1A2F, 1'b0, 1'b0);
    frame("blink_d0", 16'h1A2F, 1'b0, 1'b1);
    step();
    check_out("blink_d1 e0", 4'b1111, 7'h3F, 1'b1);
    BLINK_EN = 1'b0;
    step();
    check_out("drop e1", 4'b1111, 7'h3F, 1'b1);
    step();
    check_out("drop e2", 4'b1110, 7'h3F, 1'b1);
    step();
    check_out("drop e3", 4'b1110, 7'h3F, 1'b1);
    repeat (12) step();

    // BLINK_EN rising in the wrap cycle does not count that wrap.
    run_frame("blink_off", 16'h1A2F, 1'b0, 1'b0, 14, 16'h1A2F, 1'b1);
    frame("co_n0", 16'h1A2F, 1'b0, 1'b0);
    frame("co_n1", 16'h1A2F, 1'b0, 1'b0);
    frame("co_dark", 16'h1A2F, 1'b0, 1'b1);

    // Asynchronous reset mid digit 2.
    BLINK_EN = 1'b0;
    repeat (10) step();
    check_out("pre_rst d2", 4'b1011, 7'h3F, 1'b0);
    #2 RESET = 1'b1;
    #1;
    check_out("async_rst", 4'b1111, 7'h7F, 1'b1);
    repeat (2) step();
    RESET = 1'b0;
    step();
    check_out("restart_e1", 4'b1111, 7'h7F, 1'b1);
    frame("restart", 16'h1A2F, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed 4-digit 7-segment display driver that consumes the stopwatch's 16-bit BCD count (MM:SS). It scans one digit at a time and drives shared, active-low segment and anode lines. The count is captured once per scan frame so a frame never mixes old and new digits. It also provides leading-zero blanking, a colon (DP) on the minutes-units digit and a whole-display blink for the limit-reached indication.

## Interface
- SCAN_DIV, 50000: clk_in cycles each digit is lit; legal range ≥2.
- BLINK_DIV, 64: full scan frames per blink half-period; legal range ≥1.

- clk_in  in  1  system clock; one clock domain, all state on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Q  in  16  BCD count: Q[4:1] seconds units, Q[8:5] seconds tens, Q[12:9] minutes units, Q[16:13] minutes tens.
- LZB  in  1  1 = blank minutes-tens digit when its value is 0.
- BLINK_EN  in  1  1 = blink the whole display.
- SEG  out  7  segments a..g, SEG[1]=a … SEG[7]=g, active-low.
- DP  out  1  decimal point/colon, active-low.
- AN  out  4  digit anodes, AN[1]=seconds units … AN[4]=minutes tens, active-low, at most one low.

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1. tick = (pcnt==SCAN_DIV-1). On tick, pcnt returns to 0 and digit index idx advances 0→1→2→3→0.
- Frame snapshot: snap loads Q on the first clk_in edge after RESET deasserts (sets primed). After that it loads on every tick with idx==3, i.e. on the frame wrap. Q is never sampled at any other time.
- Digit select: idx 0→snap[4:1], 1→snap[8:5], 2→snap[12:9], 3→snap[16:13]. AN[idx+1] is driven low.
- Decode: BCD 0–9 gives the standard glyph. Values 10–15 give a dash (only g lit).
- DP is low only while idx==2 and the display is not blanked.
- Leading-zero blank: when LZB=1 and snap[16:13]==0, digit 3 has AN high, SEG all-high and DP high. Timing is unaffected.
- Blink: frame counter fcnt counts 0..BLINK_DIV-1 on each frame wrap. On its wrap, phase toggles.
  - While BLINK_EN=0, fcnt and phase are held at 0 synchronously.
  - phase=1 forces AN=4'b1111 and DP=1. SEG stays decoded.
- Not primed (first cycle after reset): AN=4'b1111, SEG=7'h7F, DP=1.

## Timing
- Reset values: AN=4'b1111, SEG=7'b1111111, DP=1, pcnt=0, idx=0, snap=0, fcnt=0, phase=0, primed=0.
- All outputs are registered. They reflect the idx/snap/phase state of the previous cycle (1-cycle latency).
- After RESET falls:
  - edge 1: snapshot taken; outputs still dark.
  - edge 2: digit 0 shown.
  - Each digit stays lit for exactly SCAN_DIV cycles.
  - Frame period is 4·SCAN_DIV cycles.
- Q changing mid-frame has no visible effect until the next frame wrap. The new snapshot is visible starting with digit 0 of the next frame.
- Frame wrap in the same cycle as a BLINK_EN rise: fcnt stays 0 (it was cleared while BLINK_EN was low). The first toggle comes BLINK_DIV frames later.
- BLINK_EN falling with phase=1: phase clears on the next edge and the display is lit on the edge after that.
- RESET asserted mid-scan: all outputs go to reset values immediately (asynchronous). After release, the full start sequence repeats.
- pcnt, idx and fcnt wrap silently; there is no overflow state.

## Structure
- Package seg7_pkg holds:
  - SEG_DIGITS=4;
  - active-low glyph constants GLYPH_0..GLYPH_9;
  - GLYPH_DASH=7'b0111111;
  - GLYPH_BLANK=7'b1111111.
- Sub-module bcd_to_seg7: purely combinational, 4-bit BCD in, 7-bit active-low SEG out, dash for 10–15.
- The top level holds prescaler, idx, snapshot, blink counter/phase and the output registers.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=2.
- Reset/start: hold Q=16'h1020, LZB=0, release RESET.
  - Edge 1: AN=1111.
  - Edges 2–5: AN=1110, SEG=GLYPH_0.
  - Then AN=1101 GLYPH_2, AN=1011 GLYPH_0 with DP=0, AN=0111 GLYPH_1.
  - Then repeat.
- Tear-free: Q=16'h4930, then change Q to 16'h4929 while digit 1 is lit.
  - The rest of the frame shows 4,9,3,0.
  - The next frame shows 4,9,2,9.
- Leading zero: Q=16'h0959, LZB=1 → the digit-3 slot has AN=1111, SEG=7F, DP=1. With LZB=0 the same slot shows GLYPH_0.
- Invalid BCD: Q=16'h1A2F → digits 0 and 2 show GLYPH_DASH (7'b0111111).
- Blink: BLINK_EN=1 → 2 frames (32 cycles) normal, then 32 cycles with AN=1111 and DP=1. Dropping BLINK_EN restores normal scanning within 2 cycles.
- Async reset: assert RESET mid-digit 2 → AN=1111, SEG=7F, DP=1 before the next clk_in edge. Scanning resumes from digit 0 per the start sequence.
